// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame format, receiver state type and baud divider helper
package uart_pkg;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop,
      RxBreak
   } UARTRxState;

   localparam int FRAME_DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;

   function automatic int baud_div(input int source_freq, input int baud_rate, input int oversample);
      int d;
      d = source_freq / (baud_rate * oversample);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_oversampler_if.sv
// rtl/uart_rx_oversampler_if.sv - serial line in, received byte and status pulses out
interface uart_rx_oversampler_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = FRAME_DATA_BITS
);
   logic                 rx_in;
   logic [DATA_BITS-1:0] rx_byte;
   logic                 rx_start;
   logic                 rx_complete;
   logic                 frame_error;
   logic                 line_break;

   modport master (
      input  rx_in,
      output rx_byte, rx_start, rx_complete, frame_error, line_break
   );

   modport slave (
      output rx_in,
      input  rx_byte, rx_start, rx_complete, frame_error, line_break
   );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running prescaler producing one tick every DIV clocks
module uart_baud_tick #(
   parameter int DIV = 4
) (
   input  logic sourceClk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_q;

   // clear suppresses the tick so a start edge always wins over a coincident tick
   assign tick = !clear && (count_q == LAST);

   always_ff @(posedge sourceClk) begin
      if (!reset || clear || tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end
endmodule

// File: rtl/uart_rx_oversampler.sv
// rtl/uart_rx_oversampler.sv - oversampling 8N1 receiver with 3-sample mid-bit majority vote
module uart_rx_oversampler
   import uart_pkg::*;
#(
   parameter int SOURCE_FREQ = 48_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = FRAME_DATA_BITS
) (
   input  logic                   sourceClk,
   input  logic                   reset,
   uart_rx_oversampler_if.master  rx
);
   localparam int DIV = baud_div(SOURCE_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2;
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_CAP0 = SW'(M - 1);
   localparam logic [SW-1:0] S_CAP1 = SW'(M);
   localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   logic rx_meta, rxs, rxs_prev;
   UARTRxState state_q, state_d;
   logic [SW-1:0] s_q;
   logic [BW-1:0] b_q;
   logic [DATA_BITS-1:0] shift_q, rx_byte_q;
   logic cap0_q, cap1_q;
   logic start_q, complete_q, ferr_q;
   logic start_d, complete_d, ferr_d;
   logic shift_en, load_byte, b_inc, b_clr;
   logic tick, clear, start_edge, vote, vote_tick, bit_end;

   assign start_edge = rxs_prev && !rxs;
   assign clear      = (state_q == RxIdle) && start_edge;
   assign vote_tick  = tick && (s_q == S_VOTE);
   assign bit_end    = tick && (s_q == S_LAST);
   // third vote sample is the live synced line at the vote tick
   assign vote       = (cap0_q & cap1_q) | (cap0_q & rxs) | (cap1_q & rxs);

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .sourceClk (sourceClk),
      .reset     (reset),
      .clear     (clear),
      .tick      (tick)
   );

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         rx_meta  <= LINE_IDLE;
         rxs      <= LINE_IDLE;
         rxs_prev <= LINE_IDLE;
      end else begin
         rx_meta  <= rx.rx_in;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   always_comb begin
      state_d    = state_q;
      start_d    = 1'b0;
      complete_d = 1'b0;
      ferr_d     = 1'b0;
      shift_en   = 1'b0;
      load_byte  = 1'b0;
      b_inc      = 1'b0;
      b_clr      = 1'b0;
      case (state_q)
         RxIdle: begin
            if (start_edge) state_d = RxStart;
         end
         RxStart: begin
            if (vote_tick) begin
               if (!vote) start_d = 1'b1;
               else       state_d = RxIdle;
            end else if (bit_end) begin
               state_d = RxData;
               b_clr   = 1'b1;
            end
         end
         RxData: begin
            if (vote_tick) begin
               shift_en = 1'b1;
            end else if (bit_end) begin
               if (b_q == B_LAST) state_d = RxStop;
               else               b_inc   = 1'b1;
            end
         end
         RxStop: begin
            // leaving at mid-stop lets the next start edge be seen straight away
            if (vote_tick) begin
               if (vote) begin
                  complete_d = 1'b1;
                  load_byte  = 1'b1;
                  state_d    = RxIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RxBreak;
               end
            end
         end
         RxBreak: begin
            if (rxs) state_d = RxIdle;
         end
         default: state_d = RxIdle;
      endcase
   end

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         state_q    <= RxIdle;
         s_q        <= '0;
         b_q        <= '0;
         shift_q    <= '0;
         rx_byte_q  <= '0;
         cap0_q     <= 1'b0;
         cap1_q     <= 1'b0;
         start_q    <= 1'b0;
         complete_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         complete_q <= complete_d;
         ferr_q     <= ferr_d;
         if (clear)                     s_q <= '0;
         else if (tick)                 s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
         if (b_clr)                     b_q <= '0;
         else if (b_inc)                b_q <= b_q + 1'b1;
         if (tick && (s_q == S_CAP0))   cap0_q <= rxs;
         if (tick && (s_q == S_CAP1))   cap1_q <= rxs;
         if (shift_en)                  shift_q <= {vote, shift_q[DATA_BITS-1:1]};
         if (load_byte)                 rx_byte_q <= shift_q;
      end
   end

   assign rx.rx_byte     = rx_byte_q;
   assign rx.rx_start    = start_q;
   assign rx.rx_complete = complete_q;
   assign rx.frame_error = ferr_q;
   assign rx.line_break  = (state_q == RxBreak);
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb/tb_uart_rx_oversampler.sv - directed frame vectors and corner-case sequences for uart_rx_oversampler
module tb_uart_rx_oversampler;
   import uart_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         period;
      int         idle_bits;
      int         glitch_bit;
      logic [7:0] exp_byte;
      int         exp_complete;
      int         exp_ferr;
   } vec_t;

   logic sourceClk = 1'b0;
   logic reset;
   int   tests = 0;
   int   failed = 0;
   int   n_start = 0, n_complete = 0, n_ferr = 0, n_both = 0;
   logic [7:0] last_byte = 8'h00;
   vec_t vecs[5];

   always #5 sourceClk = ~sourceClk;

   uart_rx_oversampler_if #(.DATA_BITS(8)) rif ();

   uart_rx_oversampler #(
      .SOURCE_FREQ (6_400_000),
      .BAUD_RATE   (100_000),
      .OVERSAMPLE  (16),
      .DATA_BITS   (8)
   ) dut (
      .sourceClk (sourceClk),
      .reset     (reset),
      .rx        (rif)
   );

   always @(negedge sourceClk) begin
      if (rif.rx_start) n_start++;
      if (rif.rx_complete) begin
         n_complete++;
         last_byte = rif.rx_byte;
      end
      if (rif.frame_error) n_ferr++;
      if (rif.rx_complete && rif.frame_error) n_both++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      rif.rx_in = v;
      repeat (n) begin
         @(posedge sourceClk);
         #1;
      end
   endtask

   // glitch lands on the centre capture (s=8) of the chosen frame bit
   task automatic send_frame(input logic [7:0] data, input int period, input logic stop, input int glitch_bit);
      logic [9:0] fr;
      fr = {stop, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (i == glitch_bit) begin
            drive_bit(fr[i], 36);
            drive_bit(~fr[i], 1);
            drive_bit(fr[i], period - 37);
         end else begin
            drive_bit(fr[i], period);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int s0, c0, f0;
      s0 = n_start; c0 = n_complete; f0 = n_ferr;
      send_frame(v.data, v.period, 1'b1, v.glitch_bit);
      drive_bit(1'b1, v.idle_bits * v.period);
      check({name, " rx_start count"},    32'(n_start - s0),    32'd1);
      check({name, " rx_complete count"}, 32'(n_complete - c0), 32'(v.exp_complete));
      check({name, " frame_error count"}, 32'(n_ferr - f0),     32'(v.exp_ferr));
      check({name, " captured byte"},     32'(last_byte),       32'(v.exp_byte));
      check({name, " rx_byte held"},      32'(rif.rx_byte),     32'(v.exp_byte));
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, " rx_byte"},     32'(rif.rx_byte),     32'h0);
      check({name, " rx_start"},    32'(rif.rx_start),    32'h0);
      check({name, " rx_complete"}, 32'(rif.rx_complete), 32'h0);
      check({name, " frame_error"}, 32'(rif.frame_error), 32'h0);
      check({name, " line_break"},  32'(rif.line_break),  32'h0);
   endtask

   initial begin
      logic [9:0] fr;
      int s0, c0, f0;
      vec_t v;

      vecs[0] = '{8'h55, 64, 0, -1, 8'h55, 1, 0};
      vecs[1] = '{8'hA3, 64, 2, -1, 8'hA3, 1, 0};
      vecs[2] = '{8'h00, 66, 2, -1, 8'h00, 1, 0};
      vecs[3] = '{8'h00, 62, 2, -1, 8'h00, 1, 0};
      vecs[4] = '{8'hC5, 64, 2,  4, 8'hC5, 1, 0};

      reset = 1'b0;
      rif.rx_in = 1'b1;
      repeat (4) @(posedge sourceClk);
      #1;
      check_outputs_zero("reset");
      check("reset state", 32'(dut.state_q), 32'(RxIdle));
      reset = 1'b1;
      drive_bit(1'b1, 64);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // short low pulse while idle: start vote sees high, no frame
      s0 = n_start; c0 = n_complete;
      drive_bit(1'b0, 12);
      drive_bit(1'b1, 128);
      check("false start rx_start",    32'(n_start - s0),    32'd0);
      check("false start rx_complete", 32'(n_complete - c0), 32'd0);
      check("false start state",       32'(dut.state_q),     32'(RxIdle));

      // framing error followed by a held-low line
      c0 = n_complete; f0 = n_ferr;
      send_frame(8'h3C, 64, 1'b0, -1);
      drive_bit(1'b0, 640);
      check("break line_break mid", 32'(rif.line_break), 32'd1);
      drive_bit(1'b0, 640);
      check("break frame_error count", 32'(n_ferr - f0),     32'd1);
      check("break rx_complete count", 32'(n_complete - c0), 32'd0);
      check("break rx_byte kept",      32'(rif.rx_byte),     32'hC5);
      check("break line_break end",    32'(rif.line_break),  32'd1);
      drive_bit(1'b1, 6);
      check("break released", 32'(rif.line_break), 32'd0);
      drive_bit(1'b1, 64);
      v = '{8'h81, 64, 2, -1, 8'h81, 1, 0};
      run_vec(v, "after break");

      // reset pulse during data bit 3 (frame bit 4) of 0x7E
      c0 = n_complete; f0 = n_ferr;
      fr = {1'b1, 8'h7E, 1'b0};
      for (int i = 0; i < 4; i++) drive_bit(fr[i], 64);
      drive_bit(fr[4], 20);
      reset = 1'b0;
      drive_bit(fr[4], 2);
      reset = 1'b1;
      check_outputs_zero("mid-frame reset");
      drive_bit(fr[4], 42);
      for (int i = 5; i < 10; i++) drive_bit(fr[i], 64);
      check("reset frame rx_complete", 32'(n_complete - c0), 32'd0);
      check("reset frame frame_error", 32'(n_ferr - f0),     32'd0);
      drive_bit(1'b1, 12 * 64);
      v = '{8'h12, 64, 2, -1, 8'h12, 1, 0};
      run_vec(v, "after reset");

      check("complete/error overlap", 32'(n_both), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
